// File: rtl/sha_bool_pipe_if.sv
// Valid/ready bundle for the SHA-2 Boolean function slot.
// The master side is the producer/consumer, the slave side is the pipe.
interface sha_bool_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/sha_bool_pipe.sv
// Pipelined SHA-2 Boolean function slot (MAJ / CH / PARITY / PASS) with tag sideband.
// The function is evaluated ahead of stage 0; later stages are stallable delay registers.

module sha_bool_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         vld_i,
  input  logic [W-1:0] pld_i,
  output logic         vld_o,
  output logic [W-1:0] pld_o
);
  logic         vld_q, vld_d;
  logic [W-1:0] pld_q, pld_d;

  always_comb begin
    vld_d = vld_q;
    pld_d = pld_q;
    if (adv_i) begin
      vld_d = vld_i;
      // Payload only moves with a real entry, so a drained output keeps its last value.
      if (vld_i) pld_d = pld_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      pld_q <= '0;
    end else begin
      vld_q <= vld_d;
      pld_q <= pld_d;
    end
  end

  assign vld_o = vld_q;
  assign pld_o = pld_q;
endmodule

module sha_bool_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  sha_bool_pipe_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_MAJ  = 2'b00,
    MODE_CH   = 2'b01,
    MODE_PAR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  localparam int PW = $bits(rsp_t);

  // vld_pipe[0]/pld_pipe[0] is the offered beat; index k+1 is the output of stage k.
  logic [STAGES:0]   vld_pipe;
  rsp_t [STAGES:0]   pld_pipe;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  fn_res;
  rsp_t              in_rsp;

  always_comb begin
    fn_res = bus.in_x;
    case (mode_e'(bus.in_mode))
      MODE_MAJ:  fn_res = (bus.in_x & bus.in_y) ^ (bus.in_x & bus.in_z) ^ (bus.in_y & bus.in_z);
      MODE_CH:   fn_res = (bus.in_x & bus.in_y) ^ (~bus.in_x & bus.in_z);
      MODE_PAR:  fn_res = bus.in_x ^ bus.in_y ^ bus.in_z;
      MODE_PASS: fn_res = bus.in_x;
      default:   fn_res = bus.in_x;
    endcase
  end

  assign in_rsp.data = fn_res;
  assign in_rsp.tag  = bus.in_tag;
  assign vld_pipe[0] = bus.in_valid;
  assign pld_pipe[0] = in_rsp;

  // A stage may load when it is empty or the stage after it is moving, so bubbles collapse.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~vld_pipe[STAGES] | bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = ~vld_pipe[k+1] | adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sha_bool_stage #(.W(PW)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv[k]),
      .vld_i (vld_pipe[k]),
      .pld_i (pld_pipe[k]),
      .vld_o (vld_pipe[k+1]),
      .pld_o (pld_pipe[k+1])
    );
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = pld_pipe[STAGES].data;
  assign bus.out_tag   = pld_pipe[STAGES].tag;
  assign bus.busy      = |vld_pipe[STAGES:1];
endmodule
